// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder: oversamples TCK/TMS/TDI on the system clock and runs the 1149.1 TAP.
// Latency: every TAP action lands 3 clock cycles after the TCK pin edge (2-flop sync + edge detect).
// Backpressure: none; the external JTAG host paces everything through TCK.
//
// Ports:
//   clock, rstb           system clock and synchronous active-low reset
//   tck, tms, tdi         asynchronous JTAG pins, synchronized internally
//   tdo, tdo_oe           data out, updated on falling TCK; enable high only in Shift-DR/Shift-IR
//   tap_state             current TAP state (0..15, TLR..UpdIR)
//   ir                    current instruction (IDCODE / BYPASS / USER, unknown values act as BYPASS)
//   user_in               value captured into the USER data register
//   user_out, user_upd    last updated USER value and its one-clock update strobe
module jtag_tap_responder #(
    parameter logic [31:0] IDCODE   = 32'h14d57048,
    parameter int          IR_LEN   = 6,
    parameter int          USER_LEN = 8
) (
    input  logic                clock,
    input  logic                rstb,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    output logic [IR_LEN-1:0]   ir,
    input  logic [USER_LEN-1:0] user_in,
    output logic [USER_LEN-1:0] user_out,
    output logic                user_upd
);

    typedef enum logic [3:0] {
        ST_TLR     = 4'd0,
        ST_RTI     = 4'd1,
        ST_SELDR   = 4'd2,
        ST_CAPDR   = 4'd3,
        ST_SHDR    = 4'd4,
        ST_EX1DR   = 4'd5,
        ST_PAUSEDR = 4'd6,
        ST_EX2DR   = 4'd7,
        ST_UPDDR   = 4'd8,
        ST_SELIR   = 4'd9,
        ST_CAPIR   = 4'd10,
        ST_SHIR    = 4'd11,
        ST_EX1IR   = 4'd12,
        ST_PAUSEIR = 4'd13,
        ST_EX2IR   = 4'd14,
        ST_UPDIR   = 4'd15
    } tap_state_t;

    localparam logic [IR_LEN-1:0] INSTR_IDCODE = IR_LEN'(6'b001001);
    localparam logic [IR_LEN-1:0] INSTR_USER   = IR_LEN'(6'b000011);
    // 1149.1 requires the two LSBs of the captured IR to read 2'b01.
    localparam logic [IR_LEN-1:0] IR_CAPTURE   = {{(IR_LEN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Pin synchronizers and TCK edge detection
    // ------------------------------------------------------------------
    logic [1:0] tck_sync;
    logic [1:0] tms_sync;
    logic [1:0] tdi_sync;
    logic       tck_prev;
    logic       tck_rise;
    logic       tck_fall;
    logic       tms_s;
    logic       tdi_s;

    // Clearing tck_prev with the synchronizers makes the first edge after
    // reset relative to a synchronized low level.
    always_ff @(posedge clock) begin
        if (!rstb) begin
            tck_sync <= 2'b00;
            tms_sync <= 2'b00;
            tdi_sync <= 2'b00;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], tck};
            tms_sync <= {tms_sync[0], tms};
            tdi_sync <= {tdi_sync[0], tdi};
            tck_prev <= tck_sync[1];
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_prev;
    assign tck_fall = ~tck_sync[1] & tck_prev;
    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge clock) begin
        if (!rstb) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                ST_TLR:     state_d = tms_s ? ST_TLR     : ST_RTI;
                ST_RTI:     state_d = tms_s ? ST_SELDR   : ST_RTI;
                ST_SELDR:   state_d = tms_s ? ST_SELIR   : ST_CAPDR;
                ST_CAPDR:   state_d = tms_s ? ST_EX1DR   : ST_SHDR;
                ST_SHDR:    state_d = tms_s ? ST_EX1DR   : ST_SHDR;
                ST_EX1DR:   state_d = tms_s ? ST_UPDDR   : ST_PAUSEDR;
                ST_PAUSEDR: state_d = tms_s ? ST_EX2DR   : ST_PAUSEDR;
                ST_EX2DR:   state_d = tms_s ? ST_UPDDR   : ST_SHDR;
                ST_UPDDR:   state_d = tms_s ? ST_SELDR   : ST_RTI;
                ST_SELIR:   state_d = tms_s ? ST_TLR     : ST_CAPIR;
                ST_CAPIR:   state_d = tms_s ? ST_EX1IR   : ST_SHIR;
                ST_SHIR:    state_d = tms_s ? ST_EX1IR   : ST_SHIR;
                ST_EX1IR:   state_d = tms_s ? ST_UPDIR   : ST_PAUSEIR;
                ST_PAUSEIR: state_d = tms_s ? ST_EX2IR   : ST_PAUSEIR;
                ST_EX2IR:   state_d = tms_s ? ST_UPDIR   : ST_SHIR;
                ST_UPDIR:   state_d = tms_s ? ST_SELDR   : ST_RTI;
                default:    state_d = ST_TLR;
            endcase
        end
    end

    assign tap_state = state_q;

    // ------------------------------------------------------------------
    // Instruction decode and data register selection
    // ------------------------------------------------------------------
    logic                sel_idcode;
    logic                sel_user;
    logic [IR_LEN-1:0]   ir_sr;
    logic [31:0]         idcode_sr;
    logic [USER_LEN-1:0] user_sr;
    logic                bypass_sr;
    logic                dr_lsb;

    // Anything that is neither IDCODE nor USER falls through to BYPASS.
    assign sel_idcode = (ir == INSTR_IDCODE);
    assign sel_user   = (ir == INSTR_USER);

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode) begin
            dr_lsb = idcode_sr[0];
        end else if (sel_user) begin
            dr_lsb = user_sr[0];
        end
    end

    // ------------------------------------------------------------------
    // Shift registers, instruction/user update and TDO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!rstb) begin
            ir        <= INSTR_IDCODE;
            ir_sr     <= '0;
            idcode_sr <= '0;
            user_sr   <= '0;
            bypass_sr <= 1'b0;
            user_out  <= '0;
            user_upd  <= 1'b0;
            tdo       <= 1'b0;
            tdo_oe    <= 1'b0;
        end else begin
            user_upd <= 1'b0;

            if (tck_rise) begin
                case (state_q)
                    ST_CAPIR: ir_sr <= IR_CAPTURE;
                    ST_SHIR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                    ST_UPDIR: ir    <= ir_sr;
                    ST_CAPDR: begin
                        if (sel_idcode) begin
                            idcode_sr <= IDCODE;
                        end else if (sel_user) begin
                            user_sr <= user_in;
                        end else begin
                            bypass_sr <= 1'b0;
                        end
                    end
                    ST_SHDR: begin
                        if (sel_idcode) begin
                            idcode_sr <= {tdi_s, idcode_sr[31:1]};
                        end else if (sel_user) begin
                            user_sr <= {tdi_s, user_sr[USER_LEN-1:1]};
                        end else begin
                            bypass_sr <= tdi_s;
                        end
                    end
                    ST_UPDDR: begin
                        if (sel_user) begin
                            user_out <= user_sr;
                            user_upd <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                // Entering TLR forces IDCODE so the instruction is valid
                // for the whole time the TAP sits in reset.
                if (state_d == ST_TLR) begin
                    ir <= INSTR_IDCODE;
                end
            end

            if (tck_fall) begin
                tdo_oe <= (state_q == ST_SHIR) || (state_q == ST_SHDR);
                if (state_q == ST_SHIR) begin
                    tdo <= ir_sr[0];
                end else if (state_q == ST_SHDR) begin
                    tdo <= dr_lsb;
                end else begin
                    tdo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: table-driven TAP walk plus hand-written
// IDCODE, BYPASS, USER, IR-capture, reset-abort and TLR-from-every-state sequences.
module tb_jtag_tap_responder;

    logic       clock = 1'b0;
    logic       rstb;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [5:0] ir;
    logic [7:0] user_in;
    logic [7:0] user_out;
    logic       user_upd;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    jtag_tap_responder #(
        .IDCODE  (32'h14d57048),
        .IR_LEN  (6),
        .USER_LEN(8)
    ) dut (
        .clock    (clock),
        .rstb     (rstb),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo),
        .tdo_oe   (tdo_oe),
        .tap_state(tap_state),
        .ir       (ir),
        .user_in  (user_in),
        .user_out (user_out),
        .user_upd (user_upd)
    );

    always #5 clock = ~clock;

    // Counts clocks with user_upd high; a clean update adds exactly one.
    always @(negedge clock) begin
        if (user_upd === 1'b1) upd_cnt++;
    end

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;   // state after the rising edge
        logic       oe;   // tdo_oe during the low phase before it
        logic       tdo;  // tdo during the low phase before it
    } vec_t;

    vec_t       vecs[30];
    logic [7:0] paths[16];
    int         lens[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One full TCK period: low phase (tdo sampled at its end), then high phase.
    task automatic tck_cycle(input logic m, input logic d, output logic tdo_s, output logic oe_s);
        tms = m;
        tdi = d;
        tck = 1'b0;
        clk_wait(6);
        tdo_s = tdo;
        oe_s  = tdo_oe;
        tck   = 1'b1;
        clk_wait(6);
    endtask

    task automatic step(input logic m, input logic d);
        logic b;
        logic oe;
        tck_cycle(m, d, b, oe);
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, input logic last_tms,
                              output logic [31:0] dout, output logic all_oe);
        logic b;
        logic oe;
        dout   = '0;
        all_oe = 1'b1;
        for (int i = 0; i < n; i++) begin
            tck_cycle((i == n - 1) ? last_tms : 1'b0, din[i], b, oe);
            dout[i] = b;
            all_oe  = all_oe & oe;
        end
    endtask

    initial begin
        logic [31:0] dout;
        logic        all_oe;
        logic        b;
        logic        oe;

        //            tms  tdi  st     oe    tdo
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd6,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd6,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd7,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd4,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd5,  1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd10, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'd12, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 4'd13, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 4'd14, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 4'd12, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[28] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0};
        vecs[29] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0};

        // TMS paths from TLR to each state, applied LSB first.
        paths[0]  = 8'b0;        lens[0]  = 0;
        paths[1]  = 8'b0;        lens[1]  = 1;
        paths[2]  = 8'b10;       lens[2]  = 2;
        paths[3]  = 8'b010;      lens[3]  = 3;
        paths[4]  = 8'b0010;     lens[4]  = 4;
        paths[5]  = 8'b1010;     lens[5]  = 4;
        paths[6]  = 8'b01010;    lens[6]  = 5;
        paths[7]  = 8'b101010;   lens[7]  = 6;
        paths[8]  = 8'b11010;    lens[8]  = 5;
        paths[9]  = 8'b110;      lens[9]  = 3;
        paths[10] = 8'b0110;     lens[10] = 4;
        paths[11] = 8'b00110;    lens[11] = 5;
        paths[12] = 8'b10110;    lens[12] = 5;
        paths[13] = 8'b010110;   lens[13] = 6;
        paths[14] = 8'b1010110;  lens[14] = 7;
        paths[15] = 8'b110110;   lens[15] = 6;

        // Reset
        rstb    = 1'b0;
        tck     = 1'b0;
        tms     = 1'b0;
        tdi     = 1'b0;
        user_in = 8'h00;
        clk_wait(4);
        check("reset tap_state", 32'(tap_state), 32'd0);
        check("reset ir",        32'(ir),        32'h09);
        check("reset tdo",       32'(tdo),       32'd0);
        check("reset tdo_oe",    32'(tdo_oe),    32'd0);
        check("reset user_out",  32'(user_out),  32'd0);
        check("reset user_upd",  32'(user_upd),  32'd0);
        rstb = 1'b1;
        clk_wait(2);

        // Table-driven TAP walk
        for (int i = 0; i < 30; i++) begin
            tck_cycle(vecs[i].tms, vecs[i].tdi, b, oe);
            check($sformatf("vec%0d tdo_oe", i),    32'(oe),        32'(vecs[i].oe));
            check($sformatf("vec%0d tdo", i),       32'(b),         32'(vecs[i].tdo));
            check($sformatf("vec%0d tap_state", i), 32'(tap_state), 32'(vecs[i].st));
        end

        // IDCODE readout
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("shdr state", 32'(tap_state), 32'd4);
        shift_bits(32, 32'h0, 1'b1, dout, all_oe);
        check("idcode value", dout, 32'h14d57048);
        check("idcode tdo_oe", 32'(all_oe), 32'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Load USER, checking the IR capture pattern on the way
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(6, 32'h03, 1'b1, dout, all_oe);
        check("ir capture user", dout, 32'h01);
        check("ir shift tdo_oe", 32'(all_oe), 32'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("ir user", 32'(ir), 32'h03);

        // USER capture/shift/update
        user_in = 8'hA5;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        upd_cnt = 0;
        shift_bits(8, 32'h3C, 1'b1, dout, all_oe);
        check("user capture", dout, 32'hA5);
        check("user_out before upd", 32'(user_out), 32'd0);
        step(1'b1, 1'b0);
        check("no upd before UpdDR", 32'(upd_cnt), 32'd0);
        step(1'b0, 1'b0);
        clk_wait(4);
        check("user_out", 32'(user_out), 32'h3C);
        check("user_upd pulses", 32'(upd_cnt), 32'd1);

        // BYPASS
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(6, 32'h3F, 1'b1, dout, all_oe);
        check("ir capture bypass", dout, 32'h01);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("ir bypass", 32'(ir), 32'h3F);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(8, 32'hFF, 1'b1, dout, all_oe);
        check("bypass stream", dout, 32'hFE);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Reset during a USER shift aborts without update
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(6, 32'h03, 1'b1, dout, all_oe);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("ir user again", 32'(ir), 32'h03);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        upd_cnt = 0;
        tck = 1'b0;
        clk_wait(6);
        check("mid-shift tdo_oe", 32'(tdo_oe), 32'd1);
        rstb = 1'b0;
        clk_wait(3);
        rstb = 1'b1;
        clk_wait(2);
        check("abort tap_state", 32'(tap_state), 32'd0);
        check("abort ir",        32'(ir),        32'h09);
        check("abort user_out",  32'(user_out),  32'd0);
        check("abort tdo_oe",    32'(tdo_oe),    32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("abort tlr hold", 32'(tap_state), 32'd0);
        check("abort no upd", 32'(upd_cnt), 32'd0);

        // TMS=1 x5 returns to TLR from every state
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < lens[s]; k++) begin
                step(paths[s][k], 1'b0);
            end
            check($sformatf("reach state %0d", s), 32'(tap_state), 32'(s));
            repeat (5) step(1'b1, 1'b0);
            check($sformatf("tlr from %0d", s), 32'(tap_state), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
